// File: rtl/siso_pkg.sv
// -----------------------------------------------------------------------------
// siso_pkg
// Shared definitions for the SISO sequencing controller:
//   seq_state_t : controller FSM states (IDLE, RUN, DONE)
//   cnt_w()     : width of the RUN-phase cycle counter for a given word width
//                 and chain depth (never less than one bit)
// -----------------------------------------------------------------------------
package siso_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // The counter spans 0..width+depth-1, so $clog2(width+depth) bits suffice.
    function automatic int cnt_w(input int width, input int depth);
        int w;
        w = $clog2(width + depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/siso_seq_ctrl.sv
// -----------------------------------------------------------------------------
// siso_seq_ctrl
// Sends a parallel word MSB-first into an external SISO shift-register chain,
// captures the same number of bits back after the chain latency, and reports
// the reassembled word together with a loopback-match flag.
//
// Parameters
//   WIDTH : bits per word
//   DEPTH : flop stages in the attached SISO chain (>= 1)
//
// Ports
//   clk        in   rising-edge clock
//   clear      in   synchronous active-high reset
//   abort      in   drop the in-flight word (only honoured in RUN)
//   in_valid   in   producer word valid
//   in_ready   out  controller can accept a word (IDLE)
//   in_data    in   word to send, bit WIDTH-1 first
//   siso_in    out  drives the chain's serial input
//   siso_clear out  drives the chain's synchronous clear
//   siso_out   in   chain's serial output
//   out_valid  out  one-cycle result pulse (DONE)
//   out_data   out  reassembled word, first captured bit in the MSB
//   out_match  out  out_data equals the accepted in_data
//   busy       out  high in RUN and DONE
// -----------------------------------------------------------------------------
module siso_seq_ctrl
    import siso_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             siso_in,
    output logic             siso_clear,
    input  logic             siso_out,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_match,
    output logic             busy
);

    localparam int CW = cnt_w(WIDTH, DEPTH);

    // Counter landmarks: transmit while cnt < CNT_TX, capture from CNT_RX0
    // onwards, leave RUN at CNT_LAST. All values fit in CW bits.
    localparam logic [CW-1:0] CNT_TX   = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_RX0  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH + DEPTH - 1);

    seq_state_t       state_q,     state_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic [WIDTH-1:0] tx_sh_q,     tx_sh_d;
    logic [WIDTH-1:0] tx_ref_q,    tx_ref_d;
    logic [WIDTH-1:0] rx_sh_q,     rx_sh_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_match_q, out_match_d;

    logic [WIDTH-1:0] rx_next;

    // Receive shift: oldest bit drifts towards the MSB. The cast drops the
    // bit that falls off the top and also covers WIDTH == 1.
    assign rx_next = WIDTH'({rx_sh_q, siso_out});

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tx_sh_q     <= '0;
            tx_ref_q    <= '0;
            rx_sh_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_match_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_sh_q     <= tx_sh_d;
            tx_ref_q    <= tx_ref_d;
            rx_sh_q     <= rx_sh_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_match_q <= out_match_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal gets its hold/default value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_sh_d     = tx_sh_q;
        tx_ref_d    = tx_ref_q;
        rx_sh_d     = rx_sh_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_match_d = out_match_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    tx_sh_d  = in_data;
                    tx_ref_d = in_data;
                    rx_sh_d  = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end

            RUN: begin
                if (abort) begin
                    // Result registers are left untouched; IDLE flushes the chain.
                    state_d = IDLE;
                end else begin
                    if (cnt_q < CNT_TX) begin
                        tx_sh_d = tx_sh_q << 1;
                    end
                    // The upper capture bound (DEPTH+WIDTH) is never reached:
                    // the terminal count leaves RUN first.
                    if (cnt_q >= CNT_RX0) begin
                        rx_sh_d = rx_next;
                    end
                    if (cnt_q == CNT_LAST) begin
                        // The last bit lands on this same edge, so the result
                        // is taken from the next-state receive register.
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = rx_sh_d;
                        out_match_d = (rx_sh_d == tx_ref_q);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q == RUN) || (state_q == DONE);
    assign siso_clear = clear || (state_q == IDLE);
    assign siso_in    = (!clear && (state_q == RUN) && (cnt_q < CNT_TX))
                        ? tx_sh_q[WIDTH-1] : 1'b0;

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_match  = out_match_q;

endmodule

// File: tb/tb_siso_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_siso_seq_ctrl
// Bench for siso_seq_ctrl with WIDTH=4, DEPTH=4. A behavioural DEPTH-stage
// SISO chain closes the loop between siso_in/siso_clear and siso_out; an
// optional inverter on siso_out models a corrupted chain.
// Expected results come from the word itself: the serial stream is the word
// MSB-first, the returned word is the sent word (or its complement when the
// chain is corrupted), and the result arrives WIDTH+DEPTH edges after the
// handshake.
// -----------------------------------------------------------------------------
module tb_siso_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int LAT   = WIDTH + DEPTH;

    logic             clk = 1'b0;
    logic             clear;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             siso_in;
    logic             siso_clear;
    logic             siso_out;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_match;
    logic             busy;

    logic             siso_inv;
    logic [DEPTH-1:0] chain;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    siso_seq_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .clear      (clear),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .siso_in    (siso_in),
        .siso_clear (siso_clear),
        .siso_out   (siso_out),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_match  (out_match),
        .busy       (busy)
    );

    // Behavioural SISO chain with synchronous clear.
    always_ff @(posedge clk) begin
        if (siso_clear) chain <= '0;
        else            chain <= {chain[DEPTH-2:0], siso_in};
    end
    assign siso_out = chain[DEPTH-1] ^ siso_inv;

    typedef struct {
        logic [WIDTH-1:0] word;
        bit               inv;
        logic [WIDTH-1:0] exp_data;
        bit               exp_match;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, in_ready, 1);
    endtask

    // Send one word and check the serial stream, latency and result.
    task automatic run_word(input logic [WIDTH-1:0] w, input bit inv,
                            input logic [WIDTH-1:0] exp_data, input bit exp_match,
                            input string tag);
        int n;
        bit seen;
        wait_ready(tag);
        siso_inv = inv;
        in_valid = 1'b1;
        in_data  = w;
        tick();                         // handshake edge
        in_valid = 1'b0;
        in_data  = '0;
        n    = 0;
        seen = 0;
        while (n <= 4 * LAT) begin
            if (n < WIDTH) check($sformatf("%s_bit%0d", tag, n), siso_in, w[WIDTH-1-n]);
            if (out_valid) begin
                seen = 1;
                break;
            end
            tick();
            n++;
        end
        if (!seen) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            check({tag, "_latency"}, n, LAT);
            check({tag, "_data"}, out_data, exp_data);
            check({tag, "_match"}, out_match, exp_match);
            tick();
            check({tag, "_pulse_end"}, out_valid, 0);
            check({tag, "_ready_again"}, in_ready, 1);
        end
        siso_inv = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        int n, k, pulses;
        int p[2];
        logic [WIDTH-1:0] d[2];
        bit m[2];

        vecs[0] = '{4'b1011, 1'b0, 4'b1011, 1'b1};
        vecs[1] = '{4'b0000, 1'b0, 4'b0000, 1'b1};
        vecs[2] = '{4'b1111, 1'b0, 4'b1111, 1'b1};
        vecs[3] = '{4'b0110, 1'b0, 4'b0110, 1'b1};
        vecs[4] = '{4'b1000, 1'b1, 4'b0111, 1'b0};
        vecs[5] = '{4'b1011, 1'b1, 4'b0100, 1'b0};   // fault injection, kept last

        clear    = 1'b1;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        siso_inv = 1'b0;

        // Reset held two cycles.
        tick();
        tick();
        check("rst_in_ready",   in_ready,   1);
        check("rst_siso_clear", siso_clear, 1);
        check("rst_siso_in",    siso_in,    0);
        check("rst_out_valid",  out_valid,  0);
        check("rst_out_data",   out_data,   0);
        check("rst_out_match",  out_match,  0);
        check("rst_busy",       busy,       0);
        clear = 1'b0;
        tick();
        check("idle_siso_clear", siso_clear, 1);

        // Randomised words against the reference model.
        for (int i = 0; i < 16; i++) begin
            logic [WIDTH-1:0] w, e;
            bit inv;
            w   = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            inv = ($urandom_range(0, 3) == 0);
            e   = inv ? ~w : w;
            repeat ($urandom_range(0, 3)) tick();
            run_word(w, inv, e, (e == w), $sformatf("rand%0d", i));
        end

        // Back-to-back with in_valid held. Each word spends WIDTH+DEPTH cycles
        // in RUN, one in DONE and one in IDLE before the next handshake.
        wait_ready("b2b");
        in_valid = 1'b1;
        in_data  = 4'b1011;
        tick();
        in_data  = 4'b0110;
        k = 0;
        n = 0;
        while (k < 2 && n < 60) begin
            if (out_valid) begin
                p[k] = n;
                d[k] = out_data;
                m[k] = out_match;
                k++;
                if (k == 2) in_valid = 1'b0;
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("b2b_pulses", k, 2);
        if (k == 2) begin
            check("b2b_first_lat", p[0], LAT);
            check("b2b_gap",       p[1] - p[0], LAT + 2);
            check("b2b_data0",     d[0], 4'b1011);
            check("b2b_match0",    m[0], 1);
            check("b2b_data1",     d[1], 4'b0110);
            check("b2b_match1",    m[1], 1);
        end

        // Table-driven vectors (nominal, edge patterns, fault injection).
        for (int i = 0; i < 6; i++) begin
            run_word(vecs[i].word, vecs[i].inv, vecs[i].exp_data, vecs[i].exp_match,
                     $sformatf("vec%0d", i));
        end

        // Abort at cnt=5: results keep the fault-injection values.
        wait_ready("abort");
        in_valid = 1'b1;
        in_data  = 4'b1100;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check("abort_busy_before", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_in_ready",  in_ready,  1);
        check("abort_busy",      busy,      0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data",  out_data,  4'b0100);
        check("abort_out_match", out_match, 0);
        pulses = 0;
        for (int i = 0; i < LAT; i++) begin
            if (out_valid) pulses++;
            tick();
        end
        check("abort_no_pulse", pulses, 0);
        run_word(4'b1001, 1'b0, 4'b1001, 1'b1, "post_abort");

        // Clear pulsed at cnt=2.
        wait_ready("midrst");
        in_valid = 1'b1;
        in_data  = 4'b0101;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        clear = 1'b1;
        tick();
        check("midrst_in_ready",   in_ready,   1);
        check("midrst_siso_clear", siso_clear, 1);
        check("midrst_siso_in",    siso_in,    0);
        check("midrst_out_valid",  out_valid,  0);
        check("midrst_out_data",   out_data,   0);
        check("midrst_out_match",  out_match,  0);
        check("midrst_busy",       busy,       0);
        clear = 1'b0;
        tick();
        run_word(4'b1111, 1'b0, 4'b1111, 1'b1, "post_midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
